// File: rtl/rr_arb4_pkg.sv
// Shared types, widths and helpers for the 4-requester round-robin arbiter.
//   NUM_REQ     : number of requesters
//   ID_W        : width of a requester index
//   req_id_t    : requester index type
//   arb_state_t : arbiter FSM state
//   rr_pick     : round-robin winner selection starting after the last owner
package rr_arb4_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set request bit scanning last+1, last+2, last+3, last+4 (mod 4).
  // Scanned from the far end so the nearest candidate is assigned last and wins.
  // The index wraps naturally in ID_W bits. Returns last when req is empty.
  function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input req_id_t            last);
    req_id_t idx;
    req_id_t win;
    win = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + ID_W'(k);
      if (req[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between up to four masters and the arbiter.
//   req       : request vector, one bit per requester
//   gnt       : one-hot grant, all-zero when idle
//   gnt_valid : high while any grant is active
//   gnt_id    : index of current or last owner
//   timeout   : one-cycle pulse on forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arb4_if;
  import rr_arb4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  req_id_t            gnt_id;
  logic               timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout
  );

endinterface

// File: rtl/rr_arb4_onehot_dec2.sv
// Combinational 2-to-4 one-hot decoder.
//   id     : input index
//   onehot : output vector with bit id set
module onehot_dec2
  import rr_arb4_pkg::*;
(
  input  req_id_t            id,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    onehot[id] = 1'b1;
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter. The grant is held until the owner drops
// its request. There is always at least one idle cycle between owners.
// With RR_ARB4_TIMEOUT_EN defined, a grant held for MAX_HOLD cycles is forcibly
// released, and timeout pulses for one cycle.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : rr_arb4_if.slave (req in; gnt, gnt_valid, gnt_id, timeout out)
// Parameter MAX_HOLD (2..255): hold limit, used only with RR_ARB4_TIMEOUT_EN.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  rr_arb4_if.slave   bus
);

  localparam int unsigned CNT_W = 8;

  // Reject an out-of-range hold limit at elaboration.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb4: MAX_HOLD must be in 2..255");
  end

  arb_state_t          state_q, state_d;
  req_id_t             gnt_id_q, gnt_id_d;
  req_id_t             last_q, last_d;
  logic [NUM_REQ-1:0]  dec_gnt;

`ifdef RR_ARB4_TIMEOUT_EN
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // Next-state and arbitration.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
`ifdef RR_ARB4_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_id_d = rr_pick(bus.req, last_q);
          state_d  = GRANT;
`ifdef RR_ARB4_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          last_d  = gnt_id_q;
          state_d = IDLE;
        end
`ifdef RR_ARB4_TIMEOUT_EN
        // The counter reads MAX_HOLD-1 during the MAX_HOLD-th grant cycle.
        else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          last_d    = gnt_id_q;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last resets to 3 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      last_q   <= req_id_t'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

`ifdef RR_ARB4_TIMEOUT_EN
  // Hold counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  onehot_dec2 u_dec (
    .id     (gnt_id_q),
    .onehot (dec_gnt)
  );

  // Grant only while in GRANT. gnt_id keeps the last owner while idle.
  assign bus.gnt       = (state_q == GRANT) ? dec_gnt : '0;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios followed by random
// request traffic, compared against an ownership-level reference model.
module tb_rr_arb4;
  import rr_arb4_pkg::*;

  localparam int unsigned TB_MAX_HOLD = 4;
`ifdef RR_ARB4_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arb4_if bus ();

  rr_arb4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: who owns the resource, who owned it last, and for how
  // many cycles the current owner has held it.
  int owner_m;
  int last_m;
  int id_m;
  int held_m;
  bit to_m;

  int n_checks;
  int n_fails;

  logic [3:0] prev_gnt;
  bit         rec_en;
  logic [3:0] order_q[$];

  task automatic model_update(input logic [3:0] r, input logic rs);
    if (rs) begin
      owner_m = -1; last_m = 3; id_m = 0; held_m = 0; to_m = 1'b0;
    end else if (owner_m < 0) begin
      to_m = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (last_m + k) % 4;
        if (r[idx] && owner_m < 0) begin
          owner_m = idx; id_m = idx; held_m = 1;
        end
      end
    end else if (!r[owner_m]) begin
      last_m = owner_m; owner_m = -1; to_m = 1'b0;
    end else if (TO_EN && held_m == int'(TB_MAX_HOLD)) begin
      last_m = owner_m; owner_m = -1; to_m = 1'b1;
    end else begin
      held_m++; to_m = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    eg = (owner_m < 0) ? 4'b0000 : 4'(1 << owner_m);
    chk("gnt",       bus.gnt, eg);
    chk("gnt_valid", {3'b000, bus.gnt_valid}, {3'b000, owner_m >= 0});
    chk("gnt_id",    {2'b00, bus.gnt_id}, 4'(id_m));
    chk("timeout",   {3'b000, bus.timeout}, {3'b000, to_m});
    if (rec_en && prev_gnt == 4'b0000 && bus.gnt != 4'b0000) order_q.push_back(bus.gnt);
    prev_gnt = bus.gnt;
  endtask

  // Apply inputs, clock once, advance the model, check on the falling edge.
  task automatic step(input logic [3:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    model_update(r, rs);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] exp_order [5];
    n_checks = 0; n_fails = 0;
    owner_m = -1; last_m = 3; id_m = 0; held_m = 0; to_m = 1'b0;
    prev_gnt = 4'b0000; rec_en = 1'b0;
    bus.req = 4'b0000; rst = 1'b1;
    @(negedge clk);

    // Reset, then a single request and its release.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Rotation with all requesting; each owner drops for one cycle after 3.
    step(4'b0000, 1'b1);
    rec_en = 1'b1;
    order_q.delete();
    for (int c = 0; c < 30; c++) begin
      r = 4'b1111;
      if (owner_m >= 0 && held_m == 3) r[owner_m] = 1'b0;
      step(r, 1'b0);
    end
    rec_en = 1'b0;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    chk("order_len", 4'(order_q.size() >= 5 ? 5 : order_q.size()), 4'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order_q.size()) chk("order", order_q[i], exp_order[i]);
    end

    // Priority after reset, then handoff to the remaining requester.
    step(4'b0000, 1'b1);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);

    // Owner 2 holds while requester 0 waits.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    for (int c = 0; c < 10; c++) step(4'b0101, 1'b0);
    step(4'b0000, 1'b0);

    // Two requesters held continuously.
    step(4'b0000, 1'b1);
    for (int c = 0; c < 12; c++) step(4'b0011, 1'b0);
    step(4'b0000, 1'b0);

    // Reset in the middle of a grant.
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom_range(0, 15));
      if (owner_m >= 0 && $urandom_range(0, 3) != 0) r[owner_m] = 1'b1;
      step(r, ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
Name: rr_arb4

Overview:
- 4-requester round-robin arbiter for a single shared resource.
- Holds the grant until the owner drops its request.
- Output grant is one-hot, produced by a 2-to-4 decoder from the registered 2-bit winner index.
- Sits between up to four masters and one shared target (e.g. a bus or memory port). It sequences ownership with a mandatory one-cycle turnaround between owners.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release. Used only when the optional feature is compiled in. Legal range 2..255.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- req  input  4  request vector; req[i] high = requester i wants or holds the resource
- gnt  output 4  one-hot grant; all-zero when idle
- gnt_valid  output 1  high while any grant is active; equals OR of gnt
- gnt_id  output 2  index of current or last owner
- timeout  output 1  one-cycle pulse on forced release; tied 0 when the feature is absent

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; all state updates on rising clk.
  - Reset values: gnt=4'b0000, gnt_valid=0, gnt_id=2'd0, timeout=0, state=IDLE, last=2'd3.
  - last=3 on reset gives requester 0 first priority.
  - rst high mid-grant: the grant drops on the next edge; no timeout pulse.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: scan indices (last+1), (last+2), (last+3), (last+4) mod 4, and take the first with req bit set.
  - Register the winner into gnt_id and go to GRANT.
  - Latency: gnt appears 1 cycle after req is sampled high in IDLE.
- GRANT:
  - gnt = one-hot decode of gnt_id: 0→0001, 1→0010, 2→0100, 3→1000. gnt_valid=1.
  - If req[gnt_id]==1: stay in GRANT. Other requests are ignored; no preemption.
  - If req[gnt_id]==0 at an edge: last<=gnt_id, go to IDLE; gnt=0 on the following cycle.
- Turnaround:
  - At least one idle cycle (gnt=0) between any two grants, including re-grant to the same requester.
  - Same-requester re-grant happens only if no other requester is pending, because that index is scanned last.
- Other rules:
  - gnt_id keeps the last owner's index while in IDLE.
  - Fairness: a continuously asserted requester waits at most 3 other ownership periods.
  - Simultaneous release by the owner and a new request from another requester: the release wins. The new request is arbitrated in IDLE on the next edge.
  - Request bits that toggle while not granted have no effect until sampled in IDLE.

Optional Feature:
- Macro: RR_ARB4_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 while req[gnt_id] is still high, force release on that edge: last<=gnt_id, state<=IDLE, and timeout=1 for exactly the next cycle (coincident with gnt=0).
  - The owner's request is then treated like any other, so it has lowest priority in the next arbitration.
- Undefined:
  - No counter logic; grant is held indefinitely while requested.
  - timeout is constant 0.
  - The port list is identical in both builds.

Decomposition:
- Package rr_arb4_pkg:
  - NUM_REQ=4, ID_W=2
  - typedef logic [ID_W-1:0] req_id_t
  - typedef enum {IDLE, GRANT} arb_state_t
- Sub-module onehot_dec2: combinational 2-to-4 one-hot decoder (input req_id_t, output 4-bit vector).
  - Instantiated once to drive gnt.
  - gnt is forced to 0 when state != GRANT.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, release; req=0100 → gnt=0100, gnt_id=2, one cycle after req sampled; req=0 → gnt=0000 next cycle.
- Round-robin rotation: req=1111 held, each owner drops its bit for 1 cycle after 3 cycles of grant → grant order 0,1,2,3,0 with a 1-cycle gnt=0 gap between each.
- Priority after reset: req=1010 simultaneously from IDLE → gnt=0010 (id 1 first, since last=3); after release with req=1000 still high → gnt=1000.
- Hold/no preemption: owner 2 holds for 10 cycles while req[0] high → gnt stays 0100 throughout. Without the macro timeout stays 0; with the macro see the next scenario.
- Timeout (RR_ARB4_TIMEOUT_EN, MAX_HOLD=4): req=0011 held continuously → gnt=0001 for exactly 4 cycles, then gnt=0000 with timeout=1 for one cycle, then gnt=0010.
- Reset mid-grant: gnt=1000 active, rst pulsed 1 cycle → next cycle gnt=0000, gnt_id=0, timeout=0; with req=1000 still high after reset → gnt=1000 one cycle after rst deasserts.
